// File: rtl/riscv_ex_cmpl_buf.sv
// riscv_ex_cmpl_buf
// In-order completion buffer for the EX stage. Entries are allocated in issue
// order at the tail, filled out of order by the execution units that own them,
// and retired in order from the head towards MEM/WB.
//
// Entry lifecycle:
//   state   | meaning
//   E_FREE  | slot unused, completions to it are ignored
//   E_PEND  | issued, waiting for its owning unit to report a result
//   E_DONE  | result captured, waiting to retire from the head
module riscv_ex_cmpl_buf #(
  parameter int XLEN  = 32,
  parameter int UNITS = 4,
  parameter int DEPTH = 4,
  localparam int UW = $clog2(UNITS),
  localparam int TW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [UW-1:0]         issue_unit,
  output logic                  issue_ready,
  output logic [TW-1:0]         issue_tag,
  input  logic [UNITS-1:0]      unit_valid,
  input  logic [UNITS*TW-1:0]   unit_tag,
  input  logic [UNITS*XLEN-1:0] unit_r,
  input  logic [UNITS-1:0]      unit_exc,
  input  logic                  wb_stall,
  output logic                  cb_valid,
  output logic [XLEN-1:0]       cb_r,
  output logic                  cb_exc,
  output logic [UW-1:0]         cb_unit,
  output logic [TW-1:0]         cb_tag,
  output logic [CW-1:0]         cb_count,
  output logic                  cb_full,
  output logic                  cb_empty
);

  typedef enum logic [1:0] {
    E_FREE = 2'd0,
    E_PEND = 2'd1,
    E_DONE = 2'd2
  } ent_state_e;

  ent_state_e      st_q   [DEPTH];
  logic [UW-1:0]   unit_q [DEPTH];
  logic [XLEN-1:0] r_q    [DEPTH];
  logic            exc_q  [DEPTH];

  logic [TW-1:0]   head_q;
  logic [TW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  logic            do_issue;
  logic            do_retire;

  logic            cmpl_hit [DEPTH];
  logic [XLEN-1:0] cmpl_r   [DEPTH];
  logic            cmpl_exc [DEPTH];

  // Occupancy flags come from the separate count so full and empty never alias.
  assign cb_count    = count_q;
  assign cb_full     = (count_q == CW'(DEPTH));
  assign cb_empty    = (count_q == '0);
  assign issue_ready = ~cb_full;
  assign issue_tag   = tail_q;

  // Head presentation straight from registered entry state.
  assign cb_valid = (st_q[head_q] == E_DONE);
  assign cb_r     = r_q[head_q];
  assign cb_exc   = exc_q[head_q];
  assign cb_unit  = unit_q[head_q];
  assign cb_tag   = head_q;

  // Issue is never allowed into a full buffer, even if the head retires now.
  assign do_issue  = issue_valid & issue_ready;
  assign do_retire = cb_valid & ~wb_stall;

  // Per-entry completion match: only the owning unit can complete a pending entry.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      cmpl_hit[e] = 1'b0;
      cmpl_r[e]   = '0;
      cmpl_exc[e] = 1'b0;
      for (int u = 0; u < UNITS; u++) begin
        if (unit_valid[u] &&
            (unit_tag[u*TW +: TW] == TW'(e)) &&
            (st_q[e] == E_PEND) &&
            (unit_q[e] == UW'(u))) begin
          cmpl_hit[e] = 1'b1;
          cmpl_r[e]   = unit_r[u*XLEN +: XLEN];
          cmpl_exc[e] = unit_exc[u];
        end
      end
    end
  end

  // Entry storage: completion capture, allocation at tail, release at head.
  // The three updates can never target the same slot in one cycle: a slot being
  // issued is FREE (no completion match), and head==tail with an issue and a
  // retire would need the buffer to be both full and non-full.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int e = 0; e < DEPTH; e++) begin
        st_q[e]   <= E_FREE;
        unit_q[e] <= '0;
        r_q[e]    <= '0;
        exc_q[e]  <= 1'b0;
      end
    end else if (flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        st_q[e] <= E_FREE;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (cmpl_hit[e]) begin
          st_q[e]  <= E_DONE;
          r_q[e]   <= cmpl_r[e];
          exc_q[e] <= cmpl_exc[e];
        end
      end
      if (do_issue) begin
        st_q[tail_q]   <= E_PEND;
        unit_q[tail_q] <= issue_unit;
      end
      if (do_retire) begin
        st_q[head_q] <= E_FREE;
      end
    end
  end

  // Circular pointers and occupancy count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_issue) begin
        tail_q <= tail_q + TW'(1);
      end
      if (do_retire) begin
        head_q <= head_q + TW'(1);
      end
      case ({do_issue, do_retire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_ex_cmpl_buf.sv
// Bench for riscv_ex_cmpl_buf: directed scenarios plus a long randomized run,
// all checked against an in-order queue model of issued operations.
module tb_riscv_ex_cmpl_buf;

  localparam int XLEN  = 32;
  localparam int UNITS = 4;
  localparam int DEPTH = 4;
  localparam int UW = $clog2(UNITS);
  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  flush;
  logic                  issue_valid;
  logic [UW-1:0]         issue_unit;
  logic                  issue_ready;
  logic [TW-1:0]         issue_tag;
  logic [UNITS-1:0]      unit_valid;
  logic [UNITS*TW-1:0]   unit_tag;
  logic [UNITS*XLEN-1:0] unit_r;
  logic [UNITS-1:0]      unit_exc;
  logic                  wb_stall;
  logic                  cb_valid;
  logic [XLEN-1:0]       cb_r;
  logic                  cb_exc;
  logic [UW-1:0]         cb_unit;
  logic [TW-1:0]         cb_tag;
  logic [CW-1:0]         cb_count;
  logic                  cb_full;
  logic                  cb_empty;

  riscv_ex_cmpl_buf #(.XLEN(XLEN), .UNITS(UNITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .issue_valid(issue_valid), .issue_unit(issue_unit),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .unit_valid(unit_valid), .unit_tag(unit_tag), .unit_r(unit_r), .unit_exc(unit_exc),
    .wb_stall(wb_stall),
    .cb_valid(cb_valid), .cb_r(cb_r), .cb_exc(cb_exc), .cb_unit(cb_unit),
    .cb_tag(cb_tag), .cb_count(cb_count), .cb_full(cb_full), .cb_empty(cb_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the list of in-flight operations in issue order.
  typedef struct {
    int              tag;
    int              unit;
    bit              done;
    logic [XLEN-1:0] r;
    bit              exc;
  } op_t;

  op_t mq[$];
  int  m_tail = 0;

  function automatic void model_step();
    bit ret, iss;
    int t;
    op_t o;
    if (!rstn || flush) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    ret = (mq.size() > 0) && mq[0].done && !wb_stall;
    iss = issue_valid && (mq.size() < DEPTH);
    for (int u = 0; u < UNITS; u++) begin
      if (unit_valid[u]) begin
        t = int'(unit_tag[u*TW +: TW]);
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].tag == t && mq[i].unit == u && !mq[i].done) begin
            o = mq[i];
            o.done = 1'b1;
            o.r    = unit_r[u*XLEN +: XLEN];
            o.exc  = unit_exc[u];
            mq[i]  = o;
          end
        end
      end
    end
    if (ret) void'(mq.pop_front());
    if (iss) begin
      o.tag = m_tail; o.unit = int'(issue_unit); o.done = 1'b0; o.r = '0; o.exc = 1'b0;
      mq.push_back(o);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endfunction

  // Advance one clock: update the model from the inputs seen at this edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    flush = 1'b0; issue_valid = 1'b0; issue_unit = '0; wb_stall = 1'b0;
    unit_valid = '0; unit_tag = '0; unit_r = '0; unit_exc = '0;
  endtask

  task automatic clr_cmpl();
    unit_valid = '0; unit_tag = '0; unit_r = '0; unit_exc = '0;
  endtask

  task automatic set_cmpl(input int u, input int t, input logic [XLEN-1:0] r, input logic e);
    unit_valid[u]           = 1'b1;
    unit_tag[u*TW +: TW]    = t[TW-1:0];
    unit_r[u*XLEN +: XLEN]  = r;
    unit_exc[u]             = e;
  endtask

  task automatic test_reset();
    clr_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    n_checks++; if (cb_empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", cb_empty); else n_pass++;
    n_checks++; if (cb_count !== CW'(0)) $display("FAIL reset_count: got %0d want 0", cb_count); else n_pass++;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", issue_ready); else n_pass++;
    n_checks++; if (cb_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", cb_valid); else n_pass++;
    n_checks++; if (issue_tag !== TW'(0)) $display("FAIL reset_issue_tag: got %0d want 0", issue_tag); else n_pass++;
    n_checks++; if (cb_full !== 1'b0) $display("FAIL reset_full: got %0b want 0", cb_full); else n_pass++;
    n_checks++; if (cb_r !== '0 || cb_exc !== 1'b0 || cb_unit !== '0)
      $display("FAIL reset_head_data: got r=%0h exc=%0b unit=%0d want 0/0/0", cb_r, cb_exc, cb_unit);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int u = 0; u < 4; u++) begin
      n_checks++; if (issue_tag !== TW'(u)) $display("FAIL fill_tag: got %0d want %0d", issue_tag, u); else n_pass++;
      issue_valid = 1'b1; issue_unit = UW'(u);
      tick();
    end
    n_checks++; if (cb_full !== 1'b1) $display("FAIL fill_full: got %0b want 1", cb_full); else n_pass++;
    n_checks++; if (issue_ready !== 1'b0) $display("FAIL fill_ready: got %0b want 0", issue_ready); else n_pass++;
    issue_unit = UW'(2);
    tick();
    issue_valid = 1'b0;
    n_checks++; if (cb_count !== CW'(4)) $display("FAIL fill_overissue_count: got %0d want 4", cb_count); else n_pass++;
    n_checks++; if (issue_tag !== TW'(0)) $display("FAIL fill_overissue_tag: got %0d want 0", issue_tag); else n_pass++;
  endtask

  task automatic test_out_of_order();
    clr_inputs();
    set_cmpl(2, 2, 32'h22, 1'b0); tick(); clr_cmpl();
    n_checks++; if (cb_valid !== 1'b0) $display("FAIL ooo_no_early_valid: got %0b want 0", cb_valid); else n_pass++;
    set_cmpl(0, 0, 32'h00, 1'b0); tick(); clr_cmpl();
    n_checks++; if (cb_valid !== 1'b1 || cb_tag !== TW'(0) || cb_r !== 32'h0)
      $display("FAIL ooo_head0: got v=%0b tag=%0d r=%0h want 1/0/0", cb_valid, cb_tag, cb_r);
    else n_pass++;
    set_cmpl(3, 3, 32'h33, 1'b0); tick(); clr_cmpl();
    n_checks++; if (cb_valid !== 1'b0 || cb_count !== CW'(3))
      $display("FAIL ooo_after_ret0: got v=%0b cnt=%0d want 0/3", cb_valid, cb_count);
    else n_pass++;
    set_cmpl(1, 1, 32'h11, 1'b0); tick(); clr_cmpl();
    for (int k = 1; k < 4; k++) begin
      n_checks++; if (cb_valid !== 1'b1 || cb_tag !== TW'(k) || cb_r !== XLEN'(k * 32'h11))
        $display("FAIL ooo_retire_order: got v=%0b tag=%0d r=%0h want 1/%0d/%0h", cb_valid, cb_tag, cb_r, k, k * 32'h11);
      else n_pass++;
      tick();
    end
    n_checks++; if (cb_empty !== 1'b1 || cb_count !== CW'(0))
      $display("FAIL ooo_drained: got empty=%0b cnt=%0d want 1/0", cb_empty, cb_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    clr_inputs();
    issue_valid = 1'b1; issue_unit = UW'(1); tick(); issue_valid = 1'b0;
    wb_stall = 1'b1;
    set_cmpl(1, 0, 32'hABCD, 1'b1); tick(); clr_cmpl();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (cb_valid !== 1'b1 || cb_r !== 32'hABCD || cb_tag !== TW'(0) || cb_count !== CW'(1) || cb_exc !== 1'b1)
        $display("FAIL stall_hold: got v=%0b r=%0h tag=%0d cnt=%0d exc=%0b want 1/abcd/0/1/1",
                 cb_valid, cb_r, cb_tag, cb_count, cb_exc);
      else n_pass++;
      tick();
    end
    wb_stall = 1'b0; tick();
    n_checks++; if (cb_count !== CW'(0) || cb_valid !== 1'b0 || issue_tag !== TW'(1))
      $display("FAIL stall_release: got cnt=%0d v=%0b tail=%0d want 0/0/1", cb_count, cb_valid, issue_tag);
    else n_pass++;
  endtask

  task automatic test_issue_retire();
    int exp_tail [3] = '{2, 3, 0};
    clr_inputs();
    for (int u = 0; u < 4; u++) begin
      issue_valid = 1'b1; issue_unit = UW'(u); tick();
    end
    issue_valid = 1'b0;
    wb_stall = 1'b1;
    set_cmpl(0, 1, 32'h51, 1'b0); tick(); clr_cmpl();
    n_checks++; if (cb_valid !== 1'b1 || cb_tag !== TW'(1) || cb_full !== 1'b1)
      $display("FAIL ir_full_head: got v=%0b tag=%0d full=%0b want 1/1/1", cb_valid, cb_tag, cb_full);
    else n_pass++;
    issue_valid = 1'b1; issue_unit = '0; wb_stall = 1'b0; tick(); issue_valid = 1'b0;
    n_checks++; if (cb_count !== CW'(3) || issue_tag !== TW'(1) || cb_valid !== 1'b0)
      $display("FAIL ir_full_blocked: got cnt=%0d tail=%0d v=%0b want 3/1/0", cb_count, issue_tag, cb_valid);
    else n_pass++;
    wb_stall = 1'b1;
    set_cmpl(1, 2, 32'h62, 1'b0); set_cmpl(2, 3, 32'h73, 1'b1); tick(); clr_cmpl();
    n_checks++; if (cb_valid !== 1'b1 || cb_tag !== TW'(2) || cb_r !== 32'h62)
      $display("FAIL ir_dual_cmpl: got v=%0b tag=%0d r=%0h want 1/2/62", cb_valid, cb_tag, cb_r);
    else n_pass++;
    wb_stall = 1'b0; tick();
    n_checks++; if (cb_count !== CW'(2) || cb_tag !== TW'(3) || cb_r !== 32'h73 || cb_exc !== 1'b1)
      $display("FAIL ir_second_dual: got cnt=%0d tag=%0d r=%0h exc=%0b want 2/3/73/1", cb_count, cb_tag, cb_r, cb_exc);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      if (!mq[0].done) begin
        wb_stall = 1'b1;
        set_cmpl(mq[0].unit, mq[0].tag, XLEN'(32'h100 + k), 1'b0); tick(); clr_cmpl();
      end
      issue_valid = 1'b1; issue_unit = UW'(k); wb_stall = 1'b0; tick(); issue_valid = 1'b0;
      n_checks++; if (cb_count !== CW'(2) || issue_tag !== TW'(exp_tail[k]))
        $display("FAIL ir_pair: got cnt=%0d tail=%0d want 2/%0d", cb_count, issue_tag, exp_tail[k]);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    clr_inputs();
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++; if (cb_count !== CW'(0) || issue_tag !== TW'(0))
      $display("FAIL flush_clean: got cnt=%0d tail=%0d want 0/0", cb_count, issue_tag);
    else n_pass++;
    for (int u = 0; u < 3; u++) begin
      issue_valid = 1'b1; issue_unit = UW'(u); tick();
    end
    n_checks++; if (cb_count !== CW'(3)) $display("FAIL flush_prefill: got %0d want 3", cb_count); else n_pass++;
    issue_unit = UW'(3); flush = 1'b1;
    set_cmpl(1, 1, 32'h99, 1'b0); tick(); clr_inputs();
    n_checks++; if (cb_count !== CW'(0) || cb_empty !== 1'b1 || issue_tag !== TW'(0) || cb_valid !== 1'b0)
      $display("FAIL flush_result: got cnt=%0d empty=%0b tail=%0d v=%0b want 0/1/0/0", cb_count, cb_empty, issue_tag, cb_valid);
    else n_pass++;
    set_cmpl(1, 1, 32'h77, 1'b0); tick(); clr_cmpl();
    n_checks++; if (cb_valid !== 1'b0 || cb_count !== CW'(0))
      $display("FAIL flush_stale_cmpl: got v=%0b cnt=%0d want 0/0", cb_valid, cb_count);
    else n_pass++;
    issue_valid = 1'b1; issue_unit = UW'(2); tick(); issue_valid = 1'b0;
    n_checks++; if (cb_count !== CW'(1) || issue_tag !== TW'(1))
      $display("FAIL flush_reissue: got cnt=%0d tail=%0d want 1/1", cb_count, issue_tag);
    else n_pass++;
  endtask

  task automatic test_random();
    int e_cnt;
    bit e_valid;
    int cand[$];
    clr_inputs();
    for (int c = 0; c < 1500; c++) begin
      e_cnt   = mq.size();
      e_valid = (e_cnt > 0) && mq[0].done;
      n_checks++; if (cb_count !== CW'(e_cnt)) $display("FAIL rnd_count: cyc %0d got %0d want %0d", c, cb_count, e_cnt); else n_pass++;
      n_checks++; if (cb_full !== (e_cnt == DEPTH) || cb_empty !== (e_cnt == 0) || issue_ready !== (e_cnt != DEPTH))
        $display("FAIL rnd_flags: cyc %0d got full=%0b empty=%0b ready=%0b for count %0d", c, cb_full, cb_empty, issue_ready, e_cnt);
      else n_pass++;
      n_checks++; if (issue_tag !== TW'(m_tail)) $display("FAIL rnd_issue_tag: cyc %0d got %0d want %0d", c, issue_tag, m_tail); else n_pass++;
      n_checks++; if (cb_valid !== e_valid) $display("FAIL rnd_valid: cyc %0d got %0b want %0b", c, cb_valid, e_valid); else n_pass++;
      if (e_valid) begin
        n_checks++; if (cb_r !== mq[0].r || cb_exc !== mq[0].exc || cb_unit !== UW'(mq[0].unit) || cb_tag !== TW'(mq[0].tag))
          $display("FAIL rnd_head: cyc %0d got r=%0h exc=%0b unit=%0d tag=%0d want %0h/%0b/%0d/%0d",
                   c, cb_r, cb_exc, cb_unit, cb_tag, mq[0].r, mq[0].exc, mq[0].unit, mq[0].tag);
        else n_pass++;
      end
      flush       = ($urandom_range(63) == 0);
      issue_valid = $urandom_range(1) == 1;
      issue_unit  = UW'($urandom_range(UNITS - 1));
      wb_stall    = ($urandom_range(3) == 0);
      clr_cmpl();
      for (int u = 0; u < UNITS; u++) begin
        if ($urandom_range(9) < 4) begin
          cand.delete();
          foreach (mq[i]) if (mq[i].unit == u && !mq[i].done) cand.push_back(mq[i].tag);
          if (cand.size() > 0 && $urandom_range(3) != 0)
            set_cmpl(u, cand[$urandom_range(cand.size() - 1)], XLEN'($urandom), 1'($urandom_range(1)));
          else
            set_cmpl(u, int'($urandom_range(DEPTH - 1)), XLEN'($urandom), 1'($urandom_range(1)));
        end
      end
      tick();
    end
    clr_inputs();
  endtask

  initial begin
    rstn = 1'b0;
    clr_inputs();
    test_reset();
    test_fill();
    test_out_of_order();
    test_stall();
    test_issue_retire();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_ex_cmpl_buf.md
Name: riscv_ex_cmpl_buf

Overview:
- Parametrised in-order completion buffer for the EX stage.
- Collects results from UNITS variable-latency execution units (ALU, LSU, MUL, DIV, future units).
- Results may arrive out of order; they retire to MEM/WB strictly in issue order.
- Replaces the fixed single-result priority mux and allows several multi-cycle operations in flight at once.

Parameters:
- XLEN, 32, datapath width.
- UNITS, 4, number of execution-unit result channels (>=2).
- DEPTH, 4, number of in-flight entries; must be a power of two, >=2.
- Localparams: UW=$clog2(UNITS), TW=$clog2(DEPTH), CW=$clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; one clock, reset is synchronous and active-low.
- flush  in  1  discard all entries (branch mispredict, st_flush, du_flush).
- issue_valid  in  1  allocate an entry this cycle.
- issue_unit  in  UW  unit that will produce the result.
- issue_ready  out  1  entry available.
- issue_tag  out  TW  tag of the entry allocated on issue (equals tail pointer).
- unit_valid  in  UNITS  per-unit completion strobe.
- unit_tag  in  UNITS*TW  per-unit completion tag (unit u at bits [u*TW+:TW]).
- unit_r  in  UNITS*XLEN  per-unit result.
- unit_exc  in  UNITS  per-unit exception flag.
- wb_stall  in  1  downstream stall.
- cb_valid  out  1  head entry complete and presented.
- cb_r  out  XLEN  head result.
- cb_exc  out  1  head exception flag.
- cb_unit  out  UW  head producing unit.
- cb_tag  out  TW  head tag.
- cb_count  out  CW  occupied entries.
- cb_full  out  1  cb_count==DEPTH.
- cb_empty  out  1  cb_count==0.

Behaviour:
- Entry state: FREE -> PENDING on issue -> DONE on matching completion -> FREE on retire or flush.
- Each entry holds state, unit, result, exc. Circular head/tail pointers, TW bits, wrap mod DEPTH. Count register is separate so full and empty are unambiguous.
- Reset (rstn low at clk edge): all entries FREE; head=tail=0; cb_count=0; cb_valid=0; cb_empty=1; cb_full=0; issue_ready=1. cb_r/cb_exc/cb_unit read 0 because entry storage resets to 0.
- Issue:
  - issue_ready = !cb_full; no same-cycle retire bypass.
  - Issue fires when issue_valid & issue_ready. Entry[tail] becomes PENDING with unit=issue_unit, and tail increments.
  - issue_valid while full is ignored; no state change.
- Completion:
  - For each u with unit_valid[u], entry[unit_tag[u]] becomes DONE and captures unit_r/unit_exc at the clock edge. This happens only if the entry is PENDING and its stored unit==u; otherwise the completion is ignored (stale or illegal).
  - Two units may complete the same cycle to different tags; both are captured. On a same-tag collision only the matching unit can qualify.
  - A completion to the tag being issued that same cycle is ignored, because the entry is still FREE.
- Retire:
  - cb_valid = (entry[head] DONE), driven combinationally from registered state. Completion at edge n gives cb_valid in cycle n+1 (1-cycle latency).
  - Retire fires when cb_valid & !wb_stall. Entry[head] becomes FREE and head increments.
  - While wb_stall is high, cb_* hold stable.
- Count: +1 on issue, -1 on retire, unchanged when both occur together.
- Flush:
  - Synchronous, highest priority over issue, completion and retire in the same cycle.
  - Result next cycle: all entries FREE, head=tail=0, count=0.
  - Completions arriving after a flush for the old tags hit FREE entries and are ignored.
- Ordering: retire order equals issue order, independent of completion order.

Test Plan:
- Reset then idle -> cb_empty=1, cb_count=0, issue_ready=1, cb_valid=0, issue_tag=0.
- Issue 4 ops (DEPTH=4) to units 0..3 -> cb_full=1, issue_ready=0. A 5th issue_valid is ignored and cb_count stays 4.
- Out-of-order completion, tags 0..3:
  - Complete tags 2,0,3,1 with r=0x22,0x00,0x33,0x11.
  - cb_valid rises for tag 0 the cycle after its completion.
  - Retire order is tags 0,1,2,3 with r=0x00,0x11,0x22,0x33.
- wb_stall held 3 cycles with head DONE -> cb_r/cb_tag stable and count unchanged. Release -> retire, head advances.
- Simultaneous issue+retire at count=4 (retire first frees nothing this cycle, so issue blocked). At count=2 -> count stays 2, tail and head both advance; wrap check: tail goes 3 -> 0.
- Flush with 3 PENDING entries plus a same-cycle completion -> next cycle count=0, head=tail=0. A later completion with the old tag=1 is ignored and cb_valid stays 0.
